// File: rtl/vram_arb.sv
// Two-port (CPU/DMA) arbiter in front of a single-port synchronous VRAM.
// Define VRAM_ARB_RR_EN for round-robin with DMA burst limit; default is CPU strict priority.
module vram_arb #(
    parameter int unsigned DMA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [12:0] cpu_addr,
    input  logic [31:0] cpu_wrdata,
    input  logic [7:0]  cpu_wrsel,
    input  logic        cpu_wren,
    output logic        cpu_ack,
    output logic [31:0] cpu_rddata,
    input  logic        dma_req,
    input  logic [12:0] dma_addr,
    input  logic [31:0] dma_wrdata,
    input  logic [7:0]  dma_wrsel,
    input  logic        dma_wren,
    output logic        dma_ack,
    output logic [31:0] dma_rddata,
    output logic [12:0] vram_addr,
    output logic [31:0] vram_wrdata,
    output logic [7:0]  vram_wrsel,
    output logic        vram_wren,
    input  logic [31:0] vram_rddata,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

    state_e      state_q, state_d;
    // Current/last-served requester: 1 = DMA, 0 = CPU.
    logic        owner_q, owner_d;
    logic [12:0] vram_addr_q, vram_addr_d;
    logic [31:0] vram_wrdata_q, vram_wrdata_d;
    logic [7:0]  vram_wrsel_q, vram_wrsel_d;
    logic        vram_wren_q, vram_wren_d;
    logic        grant_go;
    logic        grant_dma;
    logic        pick_dma;
    logic        other_req;

`ifdef VRAM_ARB_RR_EN
    localparam logic [2:0] BurstMax = 3'(DMA_BURST);
    logic [2:0] burst_q, burst_d;

    always_comb begin
        if (cpu_req && dma_req) begin
            pick_dma = !owner_q && (burst_q < BurstMax);
        end else begin
            pick_dma = dma_req;
        end
        other_req = owner_q ? cpu_req : dma_req;
    end

    always_comb begin
        burst_d = burst_q;
        if (grant_go) begin
            if (!grant_dma) begin
                burst_d = 3'd0;
            end else if (burst_q < BurstMax) begin
                burst_d = burst_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_q <= 3'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    always_comb begin
        pick_dma = !cpu_req;
        // A pending CPU request blocks the DMA hand-over; re-arbitrate from idle instead.
        other_req = owner_q ? cpu_req : (dma_req && !cpu_req);
    end
`endif

    always_comb begin
        state_d   = state_q;
        grant_go  = 1'b0;
        grant_dma = owner_q;
        case (state_q)
            StIdle: begin
                if (cpu_req || dma_req) begin
                    state_d   = StGrant;
                    grant_go  = 1'b1;
                    grant_dma = pick_dma;
                end
            end
            StGrant: state_d = StResp;
            StResp: begin
                if (other_req) begin
                    state_d   = StGrant;
                    grant_go  = 1'b1;
                    grant_dma = !owner_q;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        owner_d       = owner_q;
        vram_addr_d   = vram_addr_q;
        vram_wrdata_d = vram_wrdata_q;
        vram_wrsel_d  = vram_wrsel_q;
        vram_wren_d   = 1'b0;
        if (grant_go) begin
            owner_d       = grant_dma;
            vram_addr_d   = grant_dma ? dma_addr : cpu_addr;
            vram_wrdata_d = grant_dma ? dma_wrdata : cpu_wrdata;
            vram_wrsel_d  = grant_dma ? dma_wrsel : cpu_wrsel;
            vram_wren_d   = grant_dma ? dma_wren : cpu_wren;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            owner_q       <= 1'b1;
            vram_addr_q   <= '0;
            vram_wrdata_q <= '0;
            vram_wrsel_q  <= '0;
            vram_wren_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            vram_addr_q   <= vram_addr_d;
            vram_wrdata_q <= vram_wrdata_d;
            vram_wrsel_q  <= vram_wrsel_d;
            vram_wren_q   <= vram_wren_d;
        end
    end

    always_comb begin
        busy        = (state_q != StIdle);
        cpu_ack     = (state_q == StResp) && !owner_q;
        dma_ack     = (state_q == StResp) && owner_q;
        cpu_rddata  = cpu_ack ? vram_rddata : 32'd0;
        dma_rddata  = dma_ack ? vram_rddata : 32'd0;
        vram_addr   = vram_addr_q;
        vram_wrdata = vram_wrdata_q;
        vram_wrsel  = vram_wrsel_q;
        vram_wren   = vram_wren_q;
    end

endmodule

// File: tb/tb_vram_arb.sv
// Scoreboard bench for vram_arb with a behavioural synchronous VRAM (nibble write enables).
// Arbitration-policy scenarios follow the VRAM_ARB_RR_EN setting of the build.
module tb_vram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_wren, cpu_ack;
    logic [12:0] cpu_addr;
    logic [31:0] cpu_wrdata, cpu_rddata;
    logic [7:0]  cpu_wrsel;
    logic        dma_req, dma_wren, dma_ack;
    logic [12:0] dma_addr;
    logic [31:0] dma_wrdata, dma_rddata;
    logic [7:0]  dma_wrsel;
    logic [12:0] vram_addr;
    logic [31:0] vram_wrdata, vram_rddata;
    logic [7:0]  vram_wrsel;
    logic        vram_wren, busy;

    logic        pl_en = 1'b0;
    logic [12:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    logic [31:0] mem [0:8191];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wren_cnt = 0;
    logic [12:0] cap_addr;
    logic [31:0] cap_data;
    logic [7:0]  cap_sel;

    typedef struct {
        bit dma;
        int cyc;
    } ack_t;
    ack_t        ack_log[$];
    logic [31:0] exp_cpu[$];
    logic [31:0] exp_dma[$];
    bit          chk_cpu[$];
    bit          chk_dma[$];

    always #5 clk = ~clk;

    vram_arb #(.DMA_BURST(4)) dut (
        .clk        (clk),
        .reset      (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wrdata (cpu_wrdata),
        .cpu_wrsel  (cpu_wrsel),
        .cpu_wren   (cpu_wren),
        .cpu_ack    (cpu_ack),
        .cpu_rddata (cpu_rddata),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_wrdata (dma_wrdata),
        .dma_wrsel  (dma_wrsel),
        .dma_wren   (dma_wren),
        .dma_ack    (dma_ack),
        .dma_rddata (dma_rddata),
        .vram_addr  (vram_addr),
        .vram_wrdata(vram_wrdata),
        .vram_wrsel (vram_wrsel),
        .vram_wren  (vram_wren),
        .vram_rddata(vram_rddata),
        .busy       (busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (vram_wren) begin
            for (int i = 0; i < 8; i++) begin
                if (vram_wrsel[i]) mem[vram_addr][4*i +: 4] <= vram_wrdata[4*i +: 4];
            end
        end
        vram_rddata <= mem[vram_addr];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void expect_ack(bit dma, logic [31:0] data, bit check_data);
        if (dma) begin
            exp_dma.push_back(data);
            chk_dma.push_back(check_data);
        end else begin
            exp_cpu.push_back(data);
            chk_cpu.push_back(check_data);
        end
    endfunction

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin : monitor
        logic [31:0] d;
        bit          c;
        if (!rst) begin
            if (vram_wren) begin
                wren_cnt++;
                cap_addr = vram_addr;
                cap_data = vram_wrdata;
                cap_sel  = vram_wrsel;
            end
            if (cpu_ack && dma_ack) chk("both_acks", 32'd1, 32'd0);
            if (cpu_ack) begin
                ack_log.push_back('{dma: 1'b0, cyc: cyc});
                chk("dma_rddata_zero", dma_rddata, 32'd0);
                if (exp_cpu.size() == 0) begin
                    chk("cpu_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    d = exp_cpu.pop_front();
                    c = chk_cpu.pop_front();
                    if (c) chk("cpu_rddata", cpu_rddata, d);
                end
            end
            if (dma_ack) begin
                ack_log.push_back('{dma: 1'b1, cyc: cyc});
                chk("cpu_rddata_zero", cpu_rddata, 32'd0);
                if (exp_dma.size() == 0) begin
                    chk("dma_unexpected_ack", 32'd1, 32'd0);
                end else begin
                    d = exp_dma.pop_front();
                    c = chk_dma.pop_front();
                    if (c) chk("dma_rddata", dma_rddata, d);
                end
            end
        end
    end

    task automatic preload(input logic [12:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Single access from an idle arbiter; returns ack latency and leaves the FSM idle.
    task automatic access(input bit dma, input logic [12:0] a, input logic [31:0] wd,
                          input logic [7:0] ws, input bit we, output int lat);
        bit got = 1'b0;
        lat = 0;
        if (dma) begin
            dma_addr = a; dma_wrdata = wd; dma_wrsel = ws; dma_wren = we; dma_req = 1'b1;
        end else begin
            cpu_addr = a; cpu_wrdata = wd; cpu_wrsel = ws; cpu_wren = we; cpu_req = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = dma ? dma_ack : cpu_ack;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        if (dma) dma_req = 1'b0;
        else     cpu_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int w0;
        int cn;
        int dn;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_addr = '0; cpu_wrdata = '0; cpu_wrsel = '0; cpu_wren = 1'b0;
        dma_req = 1'b0; dma_addr = '0; dma_wrdata = '0; dma_wrsel = '0; dma_wren = 1'b0;
        @(negedge clk);
        preload(13'h0010, 32'hDEADBEEF);
        preload(13'd200, 32'hB0B0_0000);
        preload(13'd300, 32'h0BAD_F00D);
        for (int i = 0; i < 10; i++) preload(13'(100 + i), 32'hA000_0000 + i);
        for (int i = 0; i < 7; i++) preload(13'(400 + i), 32'hC000_0000 + i);
        for (int i = 0; i < 7; i++) preload(13'(500 + i), 32'hD000_0000 + i);

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
        chk("rst_wren", {31'd0, vram_wren}, 32'd0);
        chk("rst_addr", {19'd0, vram_addr}, 32'd0);
        chk("rst_wrdata", vram_wrdata, 32'd0);
        chk("rst_wrsel", {24'd0, vram_wrsel}, 32'd0);
        chk("rst_rddata", cpu_rddata | dma_rddata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // CPU read with explicit GRANT-cycle checks.
        w0 = wren_cnt;
        expect_ack(1'b0, 32'hDEADBEEF, 1'b1);
        cpu_addr = 13'h0010; cpu_wren = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        chk("rd_grant_busy", {31'd0, busy}, 32'd1);
        chk("rd_grant_addr", {19'd0, vram_addr}, 32'h10);
        chk("rd_grant_wren", {31'd0, vram_wren}, 32'd0);
        @(negedge clk);
        chk("rd_ack_latency", {31'd0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_idle_busy", {31'd0, busy}, 32'd0);
        chk("rd_no_wren", 32'(wren_cnt - w0), 32'd0);

        // CPU write then read-back.
        w0 = wren_cnt;
        expect_ack(1'b0, 32'd0, 1'b0);
        access(1'b0, 13'h1FFF, 32'h12345678, 8'hFF, 1'b1, lat);
        chk("wr_latency", 32'(lat), 32'd2);
        chk("wr_pulses", 32'(wren_cnt - w0), 32'd1);
        chk("wr_addr", {19'd0, cap_addr}, 32'h1FFF);
        chk("wr_data", cap_data, 32'h12345678);
        chk("wr_sel", {24'd0, cap_sel}, 32'hFF);
        expect_ack(1'b0, 32'h12345678, 1'b1);
        access(1'b0, 13'h1FFF, 32'd0, 8'd0, 1'b0, lat);
        chk("rb_latency", 32'(lat), 32'd2);

        // DMA alone drops req on ack: busy falls the cycle after RESP.
        expect_ack(1'b1, 32'h0BAD_F00D, 1'b1);
        access(1'b1, 13'd300, 32'd0, 8'd0, 1'b0, lat);
        chk("dma_latency", 32'(lat), 32'd2);
        chk("dma_drop_busy", {31'd0, busy}, 32'd0);

`ifdef VRAM_ARB_RR_EN
        // Both held: strict alternation, one ack every 2 cycles.
        ack_log.delete();
        for (int i = 0; i < 6; i++) expect_ack(1'b0, 32'hC000_0000 + i, 1'b1);
        for (int i = 0; i < 6; i++) expect_ack(1'b1, 32'hD000_0000 + i, 1'b1);
        cpu_addr = 13'd400; cpu_wren = 1'b0; cpu_req = 1'b1;
        dma_addr = 13'd500; dma_wren = 1'b0; dma_req = 1'b1;
        cn = 0; dn = 0;
        for (int t = 0; t < 100 && (cn < 6 || dn < 6); t++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cn++;
                if (cn < 6) cpu_addr = 13'(400 + cn);
                else        cpu_req = 1'b0;
            end
            if (dma_ack) begin
                dn++;
                if (dn < 6) dma_addr = 13'(500 + dn);
                else        dma_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("rr_alt_count", 32'(ack_log.size()), 32'd12);
        for (int k = 1; k < ack_log.size(); k++) begin
            chk("rr_alternate", {31'd0, ack_log[k].dma ^ ack_log[k-1].dma}, 32'd1);
            chk("rr_spacing", 32'(ack_log[k].cyc - ack_log[k-1].cyc), 32'd2);
        end

        // DMA alone for 6 grants, then CPU raises req: served at the next decision.
        ack_log.delete();
        for (int i = 0; i < 7; i++) expect_ack(1'b1, 32'hD000_0000 + i, 1'b1);
        expect_ack(1'b0, 32'hC000_0000, 1'b1);
        dma_addr = 13'd500; dma_req = 1'b1;
        cpu_addr = 13'd400;
        cn = 0; dn = 0;
        for (int t = 0; t < 100 && (cn < 1 || dn < 7); t++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cn++;
                cpu_req = 1'b0;
            end
            if (dma_ack) begin
                dn++;
                if (dn == 6) cpu_req = 1'b1;
                if (dn < 7) dma_addr = 13'(500 + dn);
                else        dma_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("burst_count", 32'(ack_log.size()), 32'd8);
        if (ack_log.size() == 8) begin
            chk("burst_cpu_next", {31'd0, ack_log[6].dma}, 32'd0);
            chk("burst_cpu_lat", 32'(ack_log[6].cyc - ack_log[5].cyc), 32'd2);
        end
`else
        // Both held for 10 CPU accesses: DMA waits until cpu_req drops.
        ack_log.delete();
        for (int i = 0; i < 10; i++) expect_ack(1'b0, 32'hA000_0000 + i, 1'b1);
        expect_ack(1'b1, 32'hB0B0_0000, 1'b1);
        cpu_addr = 13'd100; cpu_wren = 1'b0; cpu_req = 1'b1;
        dma_addr = 13'd200; dma_wren = 1'b0; dma_req = 1'b1;
        cn = 0; dn = 0;
        for (int t = 0; t < 100 && dn == 0; t++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cn++;
                if (cn < 10) cpu_addr = 13'(100 + cn);
                else         cpu_req = 1'b0;
            end
            if (dma_ack) begin
                dn = 1;
                dma_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("strict_count", 32'(ack_log.size()), 32'd11);
        if (ack_log.size() == 11) begin
            for (int k = 0; k < 10; k++) chk("strict_cpu_only", {31'd0, ack_log[k].dma}, 32'd0);
            chk("strict_dma_last", {31'd0, ack_log[10].dma}, 32'd1);
            chk("strict_dma_lat", 32'(ack_log[10].cyc - ack_log[9].cyc), 32'd2);
        end
`endif

        // Reset during GRANT of a write aborts it; the held request is re-served once.
        cpu_addr = 13'd5; cpu_wrdata = 32'h55AA55AA; cpu_wrsel = 8'hFF; cpu_wren = 1'b1;
        cpu_req = 1'b1;
        @(negedge clk);
        chk("rst_grant_wren", {31'd0, vram_wren}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_abort_wren", {31'd0, vram_wren}, 32'd0);
        chk("rst_abort_busy", {31'd0, busy}, 32'd0);
        chk("rst_abort_addr", {19'd0, vram_addr}, 32'd0);
        ack_log.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        w0 = wren_cnt;
        expect_ack(1'b0, 32'd0, 1'b0);
        access(1'b0, 13'd5, 32'h55AA55AA, 8'hFF, 1'b1, lat);
        chk("rst_redo_latency", 32'(lat), 32'd2);
        chk("rst_redo_pulses", 32'(wren_cnt - w0), 32'd1);
        chk("rst_redo_acks", 32'(ack_log.size()), 32'd1);
        repeat (3) @(negedge clk);

        chk("sb_cpu_empty", 32'(exp_cpu.size()), 32'd0);
        chk("sb_dma_empty", 32'(exp_dma.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
